// File: rtl/conv_pkg.sv
// Shared widths and FSM state encoding for the tile scheduler and its window register.
package conv_pkg;
    localparam int PIX_W  = 8;
    localparam int LANES  = 8;
    localparam int WIN_W  = 80;
    localparam int FILT_W = 72;
    localparam int MEM_W  = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD0 = 3'd1,
        LOADN = 3'd2,
        EMIT  = 3'd3,
        DONE  = 3'd4
    } state_t;
endpackage

// File: rtl/cbs1_win_reg.sv
// Three left/right memory-word pairs forming a 3x10 pixel window; capture, shift-left, zero-right.
module cbs1_win_reg
    import conv_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cap_en,
    input  logic             cap_right,
    input  logic [1:0]       cap_k,
    input  logic [MEM_W-1:0] cap_data,
    input  logic             shift,
    input  logic             zero_right,
    output logic [WIN_W-1:0] win_r1,
    output logic [WIN_W-1:0] win_r2,
    output logic [WIN_W-1:0] win_r3
);
    logic [2:0][MEM_W-1:0] left_q, left_d;
    logic [2:0][MEM_W-1:0] right_q, right_d;

    always_comb begin
        left_d  = left_q;
        right_d = right_q;
        if (shift)      left_d  = right_q;
        if (zero_right) right_d = '0;
        if (cap_en) begin
            if (cap_right) right_d[cap_k] = cap_data;
            else           left_d[cap_k]  = cap_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_q  <= '0;
            right_q <= '0;
        end else begin
            left_q  <= left_d;
            right_q <= right_d;
        end
    end

    // Only the two leftmost pixels of the right word extend the 8-lane window.
    assign win_r1 = {left_q[0], right_q[0][MEM_W-1 -: WIN_W-MEM_W]};
    assign win_r2 = {left_q[1], right_q[1][MEM_W-1 -: WIN_W-MEM_W]};
    assign win_r3 = {left_q[2], right_q[2][MEM_W-1 -: WIN_W-MEM_W]};
endmodule

// File: rtl/cbs1_tile_sched.sv
// Raster tile scheduler: fetches 3-row word pairs, presents 3x10 windows to an 8-lane conv array.
//   state | meaning
//   IDLE  | waiting for start; filter loads accepted
//   LOAD0 | read word 0 of rows r..r+2 into the left words
//   LOADN | read word t+1 into the right words (zero on last tile)
//   EMIT  | window valid, held until win_ready
//   DONE  | one-cycle done pulse
module cbs1_tile_sched
    import conv_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 16,
    parameter int AW    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AW-1:0]     base_addr,
    input  logic              filter_ld,
    input  logic [FILT_W-1:0] filter_in,
    output logic [FILT_W-1:0] filter_out,
    output logic              mem_rd_en,
    output logic [AW-1:0]     mem_addr,
    input  logic [MEM_W-1:0]  mem_rd_data,
    output logic [WIN_W-1:0]  win_r1,
    output logic [WIN_W-1:0]  win_r2,
    output logic [WIN_W-1:0]  win_r3,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [LANES-1:0]  win_mask,
    output logic [15:0]       win_row,
    output logic [15:0]       win_tile,
    output logic              busy,
    output logic              done
);
    localparam int          WPR       = IMG_W / 8;
    localparam logic [15:0] LAST_TILE = 16'(WPR - 1);
    localparam logic [15:0] LAST_ROW  = 16'(IMG_H - 3);

    state_t             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [15:0]        row_q, row_d, tile_q, tile_d;
    logic [AW-1:0]      base_q, base_d, addr_q, addr_d;
    logic [FILT_W-1:0]  filt_q, filt_d;
    logic               rd_en_q, rd_en_d, rd_right_q, rd_right_d;
    logic [1:0]         rd_k_q, rd_k_d;
    logic               pend_q, pend_d, pend_right_q, pend_right_d;
    logic [1:0]         pend_k_q, pend_k_d;
    logic               valid_q, valid_d, busy_q, busy_d, done_q, done_d;
    logic [LANES-1:0]   mask_q, mask_d;
    logic               shift, zero_right;
    logic [15:0]        word;
    logic [AW-1:0]      rd_addr;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        row_d        = row_q;
        tile_d       = tile_q;
        base_d       = base_q;
        filt_d       = filt_q;
        addr_d       = addr_q;
        rd_en_d      = 1'b0;
        rd_k_d       = cnt_q[1:0];
        rd_right_d   = (state_q == LOADN);
        pend_d       = rd_en_q;
        pend_k_d     = rd_k_q;
        pend_right_d = rd_right_q;
        valid_d      = valid_q;
        mask_d       = mask_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        shift        = 1'b0;
        zero_right   = 1'b0;
        word         = (state_q == LOADN) ? tile_q + 16'd1 : 16'd0;
        rd_addr      = base_q + AW'((32'(row_q) + 32'(cnt_q)) * 32'(WPR) + 32'(word));

        case (state_q)
            IDLE: begin
                if (filter_ld) filt_d = filter_in;
                if (start) begin
                    state_d = LOAD0;
                    cnt_d   = 3'd0;
                    row_d   = 16'd0;
                    tile_d  = 16'd0;
                    base_d  = base_addr;
                    busy_d  = 1'b1;
                end
            end
            LOAD0: begin
                rd_en_d = 1'b1;
                addr_d  = rd_addr;
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd2) begin
                    state_d = LOADN;
                    cnt_d   = 3'd0;
                end
            end
            LOADN: begin
                if (tile_q == LAST_TILE) begin
                    zero_right = 1'b1;
                    state_d    = EMIT;
                    valid_d    = 1'b1;
                    mask_d     = 8'hFC;
                end else begin
                    if (cnt_q < 3'd3) begin
                        rd_en_d = 1'b1;
                        addr_d  = rd_addr;
                    end
                    cnt_d = cnt_q + 3'd1;
                    // Two extra cycles let the last read return and land in the window register.
                    if (cnt_q == 3'd4) begin
                        state_d = EMIT;
                        cnt_d   = 3'd0;
                        valid_d = 1'b1;
                        mask_d  = 8'hFF;
                    end
                end
            end
            EMIT: begin
                if (win_ready) begin
                    valid_d = 1'b0;
                    mask_d  = '0;
                    cnt_d   = 3'd0;
                    if (tile_q != LAST_TILE) begin
                        shift   = 1'b1;
                        tile_d  = tile_q + 16'd1;
                        state_d = LOADN;
                    end else if (row_q != LAST_ROW) begin
                        row_d   = row_q + 16'd1;
                        tile_d  = 16'd0;
                        state_d = LOAD0;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            row_q        <= '0;
            tile_q       <= '0;
            base_q       <= '0;
            filt_q       <= '0;
            addr_q       <= '0;
            rd_en_q      <= 1'b0;
            rd_k_q       <= '0;
            rd_right_q   <= 1'b0;
            pend_q       <= 1'b0;
            pend_k_q     <= '0;
            pend_right_q <= 1'b0;
            valid_q      <= 1'b0;
            mask_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            row_q        <= row_d;
            tile_q       <= tile_d;
            base_q       <= base_d;
            filt_q       <= filt_d;
            addr_q       <= addr_d;
            rd_en_q      <= rd_en_d;
            rd_k_q       <= rd_k_d;
            rd_right_q   <= rd_right_d;
            pend_q       <= pend_d;
            pend_k_q     <= pend_k_d;
            pend_right_q <= pend_right_d;
            valid_q      <= valid_d;
            mask_q       <= mask_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    cbs1_win_reg u_win_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .cap_en     (pend_q),
        .cap_right  (pend_right_q),
        .cap_k      (pend_k_q),
        .cap_data   (mem_rd_data),
        .shift      (shift),
        .zero_right (zero_right),
        .win_r1     (win_r1),
        .win_r2     (win_r2),
        .win_r3     (win_r3)
    );

    assign filter_out = filt_q;
    assign mem_rd_en  = rd_en_q;
    assign mem_addr   = addr_q;
    assign win_valid  = valid_q;
    assign win_mask   = mask_q;
    assign win_row    = row_q;
    assign win_tile   = tile_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule

// File: tb/tb_cbs1_tile_sched.sv
// Scoreboard bench for cbs1_tile_sched: raster reference model, random handshake, stall, reset and wrap frames.
module tb_cbs1_tile_sched;
    localparam int IMG_W = 64;
    localparam int IMG_H = 16;
    localparam int AW    = 16;
    localparam int WPR   = IMG_W / 8;
    localparam int ROWS  = IMG_H - 2;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, filter_ld = 1'b0, win_ready = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [71:0]   filter_in = '0, filter_out;
    logic          mem_rd_en, win_valid, busy, done;
    logic [AW-1:0] mem_addr;
    logic [63:0]   mem_rd_data = '0;
    logic [79:0]   win_r1, win_r2, win_r3;
    logic [7:0]    win_mask;
    logic [15:0]   win_row, win_tile;

    cbs1_tile_sched #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .filter_ld(filter_ld), .filter_in(filter_in), .filter_out(filter_out),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .win_r1(win_r1), .win_r2(win_r2), .win_r3(win_r3),
        .win_valid(win_valid), .win_ready(win_ready), .win_mask(win_mask),
        .win_row(win_row), .win_tile(win_tile), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [79:0] r1, r2, r3;
        logic [7:0]  mask;
        logic [15:0] row, tile;
    } win_t;

    win_t          exp_win_q[$];
    logic [AW-1:0] exp_addr_q[$];
    win_t          held;
    int            n_cmp = 0, n_bad = 0, reads = 0, wins = 0, dones = 0, stall_cycles = 0, stall_cnt = 0;
    bit            stall_prev = 0, stall_en = 0, ready_rand = 0;

    function automatic logic [63:0] memword(logic [AW-1:0] a);
        return {a, a ^ 16'hA5C3, ~a, a + 16'h3131};
    endfunction

    function automatic logic [AW-1:0] addr_of(logic [AW-1:0] b, int row, int w);
        return AW'(int'(b) + row * WPR + w);
    endfunction

    task automatic chk(string name, logic [319:0] act, logic [319:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    // Expected windows and read addresses for a whole frame, straight from the raster definition.
    task automatic model_frame(logic [AW-1:0] b);
        for (int r = 0; r < ROWS; r++) begin
            for (int t = 0; t < WPR; t++) begin
                win_t        w;
                logic [63:0] lw, rw;
                logic [79:0] rv[3];
                for (int k = 0; k < 3; k++) begin
                    lw    = memword(addr_of(b, r + k, t));
                    rw    = (t == WPR - 1) ? 64'd0 : memword(addr_of(b, r + k, t + 1));
                    rv[k] = {lw, rw[63:48]};
                    exp_addr_q.push_back(addr_of(b, r + k, t));
                end
                w.r1   = rv[0];
                w.r2   = rv[1];
                w.r3   = rv[2];
                w.mask = (t == WPR - 1) ? 8'hFC : 8'hFF;
                w.row  = 16'(r);
                w.tile = 16'(t);
                exp_win_q.push_back(w);
            end
        end
    endtask

    always @(posedge clk) mem_rd_data <= mem_rd_en ? memword(mem_addr) : 64'({$urandom, $urandom});

    initial forever begin
        @(posedge clk);
        #1;
        if (stall_cnt > 0) begin
            win_ready = 1'b0;
            stall_cnt--;
        end else if (stall_en && win_valid && win_row == 16'd0 && win_tile == 16'd3) begin
            win_ready = 1'b0;
            stall_cnt = 4;
            stall_en  = 0;
        end else begin
            win_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd_en) begin
                reads++;
                if (exp_addr_q.size() == 0) fail_now("rd_extra");
                else chk("rd_addr", mem_addr, exp_addr_q.pop_front());
            end
            if (win_valid) begin
                win_t cur, e;
                cur = {win_r1, win_r2, win_r3, win_mask, win_row, win_tile};
                chk("rd_in_emit", mem_rd_en, 0);
                if (stall_prev) chk("stall_hold", cur, held);
                if (!win_ready && !ready_rand) stall_cycles++;
                if (win_ready) begin
                    wins++;
                    stall_prev = 0;
                    if (exp_win_q.size() == 0) fail_now("win_extra");
                    else begin
                        e = exp_win_q.pop_front();
                        chk("win_r1", win_r1, e.r1);
                        chk("win_r2", win_r2, e.r2);
                        chk("win_r3", win_r3, e.r3);
                        chk("win_mask", win_mask, e.mask);
                        chk("win_idx", {win_row, win_tile}, {e.row, e.tile});
                    end
                end else begin
                    held       = cur;
                    stall_prev = 1;
                end
            end
            if (done) dones++;
        end
    end

    task automatic check_zero(string tag);
        chk({tag, "_win"}, {win_r1, win_r2, win_r3}, 0);
        chk({tag, "_ctl"}, {mem_rd_en, mem_addr, win_mask, win_row, win_tile, busy, done, win_valid, filter_out}, 0);
    endtask

    task automatic load_filter(logic [71:0] v);
        @(posedge clk); #1;
        filter_ld = 1'b1;
        filter_in = v;
        @(posedge clk); #1;
        filter_ld = 1'b0;
        @(negedge clk);
        chk("filter_load", filter_out, v);
    endtask

    task automatic issue_start(logic [AW-1:0] b);
        model_frame(b);
        reads = 0;
        wins  = 0;
        dones = 0;
        @(posedge clk); #1;
        base_addr = b;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        base_addr = AW'($urandom);
        @(negedge clk);
        chk("busy_rise", busy, 1);
    endtask

    task automatic run_frame(logic [AW-1:0] b, bit poke);
        bit got;
        issue_start(b);
        if (poke) begin
            repeat (10) @(posedge clk);
            #1;
            filter_ld = 1'b1;
            filter_in = 72'h010203040506070809;
            start     = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            filter_ld = 1'b0;
        end
        got = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
        end
        if (!got) fail_now("done_timeout");
        @(negedge clk);
        chk("busy_fall", {busy, done}, 2'b00);
        repeat (3) @(negedge clk);
        chk("reads", reads, ROWS * 3 * WPR);
        chk("wins", wins, ROWS * WPR);
        chk("dones", dones, 1);
        chk("q_empty", exp_win_q.size() + exp_addr_q.size(), 0);
    endtask

    initial begin
        logic [71:0] fa;
        bit          got;
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst0");
        @(negedge clk) rst_n = 1'b1;

        fa = 72'({$urandom, $urandom, $urandom});
        load_filter(fa);

        stall_en   = 1;
        ready_rand = 0;
        run_frame(AW'($urandom), 1'b1);
        chk("filter_hold", filter_out, fa);
        chk("stall_cycles", stall_cycles, 5);
        load_filter(72'h010203040506070809);

        ready_rand = 1;
        run_frame(16'hFFFE, 1'b0);

        issue_start(AW'($urandom));
        got = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            if (mem_rd_en && reads == 8) begin
                got = 1;
                break;
            end
        end
        if (!got) fail_now("abort_wait");
        rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        stall_prev = 0;
        exp_win_q.delete();
        exp_addr_q.delete();
        repeat (3) @(negedge clk);
        check_zero("rst_hold");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_after_rst", {busy, mem_rd_en, win_valid}, 3'b000);

        run_frame(AW'($urandom), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
